timer_counter: RTL and testbench

- Programmable 32-bit up/down timebase with an optional clock prescaler.
- Its `counter` output drives the `counter` input of the compare/match stage.
- `tick` and `wrap` give single-cycle strobes to the interrupt logic.
- Supports free-running (wrap-around) and one-shot (stop at terminal value) modes, plus synchronous load.

---
 rtl/timer_counter.sv | 124 ++++++++++++
 tb/tb_timer_counter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Programmable up/down timebase with free-running and one-shot modes and synchronous load.
// Optional clock prescaler enabled by defining TIMER_COUNTER_PRESCALE_EN.
module timer_counter #(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               dir,
    input  logic               oneshot,
    output logic [WIDTH-1:0]   counter,
    output logic               tick,
    output logic               wrap,
    output logic               running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_counter;
    logic               r_tick;
    logic               r_wrap;
    logic               r_running;

    logic               w_stepDue;
    logic [WIDTH-1:0]   w_next;
    logic               w_atTerm;
    logic               w_nextTerm;
    logic               w_stop;

    assign w_next     = dir ? (r_counter - WIDTH'(1)) : (r_counter + WIDTH'(1));
    assign w_atTerm   = dir ? (r_counter == '0) : (r_counter == '1);
    assign w_nextTerm = dir ? (w_next == '0) : (w_next == '1);
    // Stepping off the terminal value is a wrap, never a stop, even in one-shot mode.
    assign w_stop     = oneshot && w_nextTerm && !w_atTerm;

`ifdef TIMER_COUNTER_PRESCALE_EN
    logic [PRESC_W-1:0] r_presc;

    // Using >= means a prescale value lowered mid-run still releases the next step.
    assign w_stepDue = (r_presc >= prescale);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
        end else if (r_state == RUN && enable && !w_stepDue) begin
            r_presc <= r_presc + PRESC_W'(1);
        end else begin
            r_presc <= '0;
        end
    end
`else
    logic w_unused_prescale;

    assign w_stepDue         = 1'b1;
    assign w_unused_prescale = ^prescale;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else if (load) begin
            r_state   <= IDLE;
            r_counter <= load_value;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end else if (w_stepDue) begin
                        r_counter <= w_next;
                        r_tick    <= 1'b1;
                        r_wrap    <= w_atTerm || w_stop;
                        if (w_stop) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign counter = r_counter;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign running = r_running;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed stimulus queues expected outputs,
// a monitor pops and compares them on the falling clock edge.
module tb_timer_counter;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_value = '0;
    logic [15:0] prescale = '0;
    logic        dir = 1'b0;
    logic        oneshot = 1'b0;
    logic [31:0] counter;
    logic        tick;
    logic        wrap;
    logic        running;

    int checks = 0;
    int errors = 0;

`ifdef TIMER_COUNTER_PRESCALE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] cnt;
        logic        tk;
        logic        wr;
        logic        run;
    } exp_t;

    exp_t q[$];

    timer_counter #(.WIDTH(32), .PRESC_W(16)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .load_value(load_value),
        .prescale  (prescale),
        .dir       (dir),
        .oneshot   (oneshot),
        .counter   (counter),
        .tick      (tick),
        .wrap      (wrap),
        .running   (running)
    );

    always #5 clk_in = ~clk_in;

    function automatic int spacing(input int p);
        return PEN ? p + 1 : 1;
    endfunction

    task automatic applyStimulus(input logic ld, input logic [31:0] lv, input logic en,
                                 input logic [15:0] p, input logic d, input logic os);
        load       = ld;
        load_value = lv;
        enable     = en;
        prescale   = p;
        dir        = d;
        oneshot    = os;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] c, input logic t,
                               input logic w, input logic r);
        exp_t e;
        e.name = nm;
        e.cnt  = c;
        e.tk   = t;
        e.wr   = w;
        e.run  = r;
        q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Each step is preceded by sp-1 quiet RUN cycles; none of these steps reach a terminal value.
    task automatic runSteps(input int n, input int sp, inout logic [31:0] cur,
                            input bit down, input string nm);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < sp - 1; j++) begin
                cycle();
                checkOutput({nm, "_wait"}, cur, 1'b0, 1'b0, 1'b1);
            end
            cycle();
            cur = down ? cur - 32'd1 : cur + 32'd1;
            checkOutput({nm, "_step"}, cur, 1'b1, 1'b0, 1'b1);
        end
    endtask

    // Monitor: every queued expectation is compared against the outputs on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (counter !== e.cnt || tick !== e.tk || wrap !== e.wr || running !== e.run) begin
                    errors++;
                    $display("[TB] FAIL %s: got cnt=%h tick=%b wrap=%b run=%b, expected cnt=%h tick=%b wrap=%b run=%b",
                             e.name, counter, tick, wrap, running, e.cnt, e.tk, e.wr, e.run);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] cur;
        int sp;

        applyStimulus(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        checkOutput("reset_init", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        $display("[TB] prescaled up-count P=3");
        applyStimulus(1'b1, 32'h0, 1'b0, 16'd3, 1'b0, 1'b0);
        cycle();
        checkOutput("pu_load", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd3, 1'b0, 1'b0);
        cycle();
        checkOutput("pu_e0", 32'h0, 1'b0, 1'b0, 1'b1);
        cur = 32'h0;
        runSteps(3, spacing(3), cur, 1'b0, "pu");
        enable = 1'b0;
        cycle();
        checkOutput("pu_hold", 32'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b1, 32'h12, 1'b0, 16'd100, 1'b0, 1'b0);
        cycle();
        checkOutput("rst_load", 32'h12, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        load   = 1'b0;
        cycle();
        checkOutput("rst_run", 32'h12, 1'b0, 1'b0, 1'b1);
        cycle();
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", 32'h0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        checkOutput("rst_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] free-running wrap");
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0, 16'd0, 1'b0, 1'b0);
        cycle();
        checkOutput("fw_load", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 1'b0);
        cycle();
        checkOutput("fw_e0", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("fw_ones", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        cycle();
        checkOutput("fw_zero", 32'h0, 1'b1, 1'b1, 1'b1);
        cycle();
        checkOutput("fw_one", 32'h1, 1'b1, 1'b0, 1'b1);
        enable = 1'b0;
        cycle();
        checkOutput("fw_stop", 32'h1, 1'b0, 1'b0, 1'b0);

        $display("[TB] one-shot down-count");
        applyStimulus(1'b1, 32'd3, 1'b0, 16'd0, 1'b1, 1'b1);
        cycle();
        checkOutput("os_load", 32'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd0, 1'b1, 1'b1);
        cycle();
        checkOutput("os_e0", 32'd3, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("os_2", 32'd2, 1'b1, 1'b0, 1'b1);
        cycle();
        checkOutput("os_1", 32'd1, 1'b1, 1'b0, 1'b1);
        cycle();
        checkOutput("os_0", 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkOutput("os_done", 32'd0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'd5, 1'b1, 16'd0, 1'b1, 1'b1);
        cycle();
        checkOutput("os_reload", 32'd5, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        cycle();
        checkOutput("os_restart", 32'd5, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("os_4", 32'd4, 1'b1, 1'b0, 1'b1);

        $display("[TB] one-shot entered at terminal value");
        applyStimulus(1'b1, 32'h0, 1'b0, 16'd0, 1'b1, 1'b1);
        cycle();
        checkOutput("ost_load", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd0, 1'b1, 1'b1);
        cycle();
        checkOutput("ost_e0", 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("ost_wrap", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        cycle();
        checkOutput("ost_next", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);

        $display("[TB] load colliding with a due step");
        applyStimulus(1'b1, 32'h50, 1'b0, 16'd0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        checkOutput("sim_pre", 32'h51, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1, 16'd0, 1'b0, 1'b0);
        cycle();
        checkOutput("sim_load", 32'h100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd2, 1'b0, 1'b0);
        cycle();
        checkOutput("sim_e0", 32'h100, 1'b0, 1'b0, 1'b1);
        sp  = spacing(2);
        cur = 32'h100;
        cycle();
        if (sp == 1) cur = cur + 32'd1;
        checkOutput("sim_first", cur, (sp == 1), 1'b0, 1'b1);
        enable = 1'b0;
        cycle();
        checkOutput("sim_pause", cur, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        cycle();
        checkOutput("sim_resume", cur, 1'b0, 1'b0, 1'b1);
        runSteps(1, sp, cur, 1'b0, "sim");

        $display("[TB] prescale P=7");
        applyStimulus(1'b1, 32'h0, 1'b0, 16'd7, 1'b0, 1'b0);
        cycle();
        checkOutput("p7_load", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 16'd7, 1'b0, 1'b0);
        cycle();
        checkOutput("p7_e0", 32'h0, 1'b0, 1'b0, 1'b1);
        cur = 32'h0;
        runSteps(3, spacing(7), cur, 1'b0, "p7");

        enable = 1'b0;
        cycle();
        checkOutput("final_idle", cur, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk_in);
        end
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
